rc4_encryptor: RTL and testbench
================================

# rc4_encryptor

Single-key RC4 stream encryptor: the encrypt-direction counterpart of the key-search decryption cores. It latches a 24-bit secret key on `start` and runs the RC4 key schedule over an internal 256-byte state array. It then XORs a plaintext byte stream with the generated keystream and emits ciphertext through a valid/ready handshake. It produces test messages (ciphertext MIF contents) for the cracking datapath and can run standalone on the DE1-SoC.

## Interface
- `MSG_LEN`, default 32: number of bytes encrypted per `start` (1..255).
- `clk` in 1: system clock (CLOCK_50).
- `reset` in 1: asynchronous, active-high; returns the block to IDLE.
- `start` in 1: begin an encryption run; sampled only in IDLE.
- `secret_key` in 24: key bytes are key[0]=[23:16], key[1]=[15:8], key[2]=[7:0]. Latched on the cycle `start` is accepted.
- `busy` out 1: high from the cycle after `start` is accepted through the DONE cycle.
- `done` out 1: one-cycle pulse after the last ciphertext byte is accepted.
- `pt_valid` in 1, `pt_data` in 8: plaintext byte offered.
- `pt_ready` out 1: high only in PT_WAIT.
- `ct_valid` out 1, `ct_data` out 8: ciphertext byte offered.
- `ct_ready` in 1: downstream accepts ciphertext.
- `byte_count` out 8: number of ciphertext bytes accepted in the current run (for HEX display).

## Operation
- States: IDLE, INIT, KSA_J, KSA_SWAP, PT_WAIT, PRGA_J, PRGA_SWAP, CT_OUT, DONE.
- IDLE: if `start`=1, latch the key, clear i, j, byte_count, and go to INIT.
- INIT: s[i]<=i, i++. After i=255, go to KSA_J with i=0, j=0.
- KSA_J: j<=j+s[i]+key[i mod 3].
- KSA_SWAP: swap s[i] and s[j], i++. After i=255, clear i and j and go to PT_WAIT; otherwise go to KSA_J.
- PT_WAIT: `pt_ready`=1. On `pt_valid`: latch `pt_data`, i<=i+1, go to PRGA_J.
- PRGA_J: j<=j+s[i].
- PRGA_SWAP: swap s[i] and s[j].
- CT_OUT (entry): `ct_data`<=s[(s[i]+s[j]) mod 256] XOR the latched plaintext byte; `ct_valid`<=1.
- CT_OUT (hold): `ct_valid` stays high and `ct_data` stays stable until `ct_ready`=1. On acceptance, byte_count++. Go to DONE if byte_count reaches MSG_LEN, else to PT_WAIT.
- DONE: `done`=1 for one cycle, then IDLE.
- Arithmetic: all index and j arithmetic is 8-bit modulo 256. The key-byte index is i mod 3, using a 2-bit counter that wraps 2->0.
- S storage: internal register array with combinational read. Contents are undefined outside a run; every run reinitialises S in INIT.
- `start` while `busy` is ignored. `pt_valid` outside PT_WAIT is ignored, and no data is consumed.
- `secret_key` changes after acceptance have no effect on the current run.

## Timing
- Reset values: `busy`=0, `done`=0, `pt_ready`=0, `ct_valid`=0, `ct_data`=0, `byte_count`=0, state=IDLE, i=j=0.
- Reset takes effect immediately, even mid-run. The next `start` produces correct output.
- Start acceptance at edge 0; INIT occupies cycles 1-256; KSA occupies cycles 257-768 (2 cycles per iteration). `pt_ready` first rises in cycle 769.
- A plaintext handshake in cycle N gives `ct_valid`=1 in cycle N+3.
- After ciphertext acceptance in cycle M, `pt_ready` rises again in cycle M+1.
- Full-speed throughput is 4 cycles per byte.
- Ciphertext acceptance of the final byte in cycle M gives `done`=1 in cycle M+1 and `busy`=0 in cycle M+2.
- `pt_ready` and `ct_valid` are never high in the same cycle.

## Test plan
- Known-answer: MSG_LEN=9, key 24'h4B6579 ("Key"), plaintext "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> ciphertext BB F3 16 E8 D9 40 AF 0A D3. Expect exactly one `done` pulse and `byte_count`=9.
- Round trip: re-run with the same key, feeding BB F3 16 E8 D9 40 AF 0A D3 as plaintext -> output 50 6C 61 69 6E 74 65 78 74.
- Backpressure: hold `ct_ready`=0 for 10 cycles on byte 3 of the known-answer run. Required: `ct_data`=16 stable, `ct_valid` high, `pt_ready` low throughout, and the full ciphertext unchanged.
- Latency: start accepted at cycle 0 -> `pt_ready` first high at cycle 769. Plaintext handshake at cycle N -> `ct_valid` at N+3.
- Control hazards:
  - Pulse `start` with key 24'h000000 during KSA: ignored, and the output still matches the known answer.
  - Assert `reset` in cycle 400: all outputs at reset values within the same cycle.
  - Next run with key 24'h4B6579 reproduces BB F3 16 ... D3.
- `pt_valid` held high in IDLE and INIT: no byte consumed, `byte_count` stays 0, and the first ciphertext byte is 0xBB.

Source files
------------

// File: rtl/rc4_encryptor_if.sv
// Control, plaintext and ciphertext handshake bundle for rc4_encryptor.
interface rc4_encryptor_if;
    logic        start;
    logic [23:0] secret_key;
    logic        busy;
    logic        done;
    logic        pt_valid;
    logic [7:0]  pt_data;
    logic        pt_ready;
    logic        ct_valid;
    logic [7:0]  ct_data;
    logic        ct_ready;
    logic [7:0]  byte_count;

    modport master (
        output start, secret_key, pt_valid, pt_data, ct_ready,
        input  busy, done, pt_ready, ct_valid, ct_data, byte_count
    );

    modport slave (
        input  start, secret_key, pt_valid, pt_data, ct_ready,
        output busy, done, pt_ready, ct_valid, ct_data, byte_count
    );
endinterface

// File: rtl/rc4_encryptor.sv
// Single-key RC4 stream encryptor: key schedule over a 256-byte register S,
// then one keystream byte per plaintext byte through valid/ready handshakes.
module rc4_encryptor #(
    parameter int unsigned MSG_LEN = 32
) (
    input logic          clk,
    input logic          reset,
    rc4_encryptor_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, INIT, KSA_J, KSA_SWAP, PT_WAIT, PRGA_J, PRGA_SWAP, CT_OUT, DONE
    } state_e;

    localparam logic [7:0] LEN8 = 8'(MSG_LEN);

    state_e      state_q;
    logic [7:0]  s_q [256];
    logic [7:0]  i_q, j_q, pt_q, ct_q, cnt_q;
    logic [1:0]  k_q;
    logic [23:0] key_q;
    logic        busy_q, done_q, pt_ready_q, ct_valid_q;

    logic [7:0]  si, sj, t, key_byte;
    logic [7:0]  j_ksa_d, j_prga_d, ks_d, cnt_d;

    always_comb begin
        si = s_q[i_q];
        sj = s_q[j_q];
        case (k_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
        j_ksa_d  = j_q + si + key_byte;
        j_prga_d = j_q + si;
        t        = si + sj;
        // Keystream byte is taken from S as it will look after this cycle's swap.
        if (t == i_q)      ks_d = sj;
        else if (t == j_q) ks_d = si;
        else               ks_d = s_q[t];
        cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        case (state_q)
            INIT: s_q[i_q] <= i_q;
            KSA_SWAP, PRGA_SWAP: begin
                s_q[i_q] <= sj;
                s_q[j_q] <= si;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            key_q      <= '0;
            pt_q       <= '0;
            ct_q       <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pt_ready_q <= 1'b0;
            ct_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        key_q   <= bus.secret_key;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    i_q <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        j_q     <= '0;
                        k_q     <= '0;
                        state_q <= KSA_J;
                    end
                end
                KSA_J: begin
                    j_q     <= j_ksa_d;
                    state_q <= KSA_SWAP;
                end
                KSA_SWAP: begin
                    i_q <= i_q + 8'd1;
                    k_q <= (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
                    if (i_q == 8'hFF) begin
                        j_q        <= '0;
                        pt_ready_q <= 1'b1;
                        state_q    <= PT_WAIT;
                    end else begin
                        state_q <= KSA_J;
                    end
                end
                PT_WAIT: begin
                    if (bus.pt_valid) begin
                        pt_q       <= bus.pt_data;
                        i_q        <= i_q + 8'd1;
                        pt_ready_q <= 1'b0;
                        state_q    <= PRGA_J;
                    end
                end
                PRGA_J: begin
                    j_q     <= j_prga_d;
                    state_q <= PRGA_SWAP;
                end
                PRGA_SWAP: begin
                    ct_q       <= ks_d ^ pt_q;
                    ct_valid_q <= 1'b1;
                    state_q    <= CT_OUT;
                end
                CT_OUT: begin
                    if (bus.ct_ready) begin
                        ct_valid_q <= 1'b0;
                        cnt_q      <= cnt_d;
                        if (cnt_d == LEN8) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            pt_ready_q <= 1'b1;
                            state_q    <= PT_WAIT;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pt_ready   = pt_ready_q;
    assign bus.ct_valid   = ct_valid_q;
    assign bus.ct_data    = ct_q;
    assign bus.byte_count = cnt_q;

endmodule

// File: tb/tb_rc4_encryptor.sv
// Bench for rc4_encryptor (MSG_LEN=9): vector table, control-hazard sequences
// and randomized runs against a plain-array RC4 reference.
module tb_rc4_encryptor;

    typedef logic [7:0] msg_t [9];
    typedef struct packed {
        logic [23:0] key;
        logic [71:0] pt;
        logic [71:0] ct;
    } vec_t;

    localparam logic [23:0] KAT_KEY = 24'h4B6579;
    localparam logic [71:0] KAT_PT  = 72'h506C61696E74657874;
    localparam logic [71:0] KAT_CT  = 72'hBBF316E8D940AF0AD3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   excl_cnt = 0;

    rc4_encryptor_if bus_if ();

    rc4_encryptor #(.MSG_LEN(9)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus_if.done) done_cnt++;
        if (bus_if.pt_ready && bus_if.ct_valid) excl_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    function automatic void to_msg(input logic [71:0] v, output msg_t m);
        for (int k = 0; k < 9; k++) m[k] = v[71-8*k -: 8];
    endfunction

    // Textbook RC4: KSA then PRGA, all on integers modulo 256.
    function automatic void rc4_ref(input logic [23:0] key, input msg_t pt, output msg_t ct);
        int s[256];
        int kb[3];
        int j, i, tmp;
        kb[0] = int'(key[23:16]);
        kb[1] = int'(key[15:8]);
        kb[2] = int'(key[7:0]);
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + kb[n % 3]) % 256;
            tmp = s[n]; s[n] = s[j]; s[j] = tmp;
        end
        i = 0;
        j = 0;
        for (int n = 0; n < 9; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            ct[n] = pt[n] ^ 8'(s[(s[i] + s[j]) % 256]);
        end
    endfunction

    // mode 0: plain, 1: start pulse with key 0 during KSA, 3: pt_valid held from IDLE.
    task automatic run_msg(input logic [23:0] key, input msg_t pt, input msg_t exp,
                           input int mode, input int stall_byte, input int stall_len,
                           input bit rnd);
        int c0, rel, n, w, d0;
        d0 = done_cnt;
        if (mode == 3) begin
            bus_if.pt_valid = 1'b1;
            bus_if.pt_data  = pt[0];
        end
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.secret_key = key;
        @(negedge clk);
        bus_if.start      = 1'b0;
        bus_if.secret_key = ~key;
        c0 = cyc - 1;
        chk("busy_after_start", bus_if.busy, 1'b1);
        for (int b = 0; b < 9; b++) begin
            if (rnd && b > 0) repeat ($urandom_range(0, 3)) @(negedge clk);
            w = 0;
            while (!bus_if.pt_ready && w < 2000) begin
                rel = cyc - c0;
                if (mode == 1 && rel == 400) begin
                    bus_if.start      = 1'b1;
                    bus_if.secret_key = 24'h000000;
                end else if (mode == 1 && rel == 401) begin
                    bus_if.start = 1'b0;
                end
                if (mode == 3 && (rel == 100 || rel == 768))
                    chk("byte_count_pre", bus_if.byte_count, 8'd0);
                @(negedge clk);
                w++;
            end
            if (!bus_if.pt_ready) begin
                fail_now("pt_ready_wait");
                bus_if.pt_valid = 1'b0;
                return;
            end
            rel = cyc - c0;
            if (b == 0) chk("pt_ready_latency", rel, 769);
            bus_if.pt_valid = 1'b1;
            bus_if.pt_data  = pt[b];
            n = rel;
            @(negedge clk);
            bus_if.pt_valid = 1'b0;
            w = 0;
            while (!bus_if.ct_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!bus_if.ct_valid) begin
                fail_now("ct_valid_wait");
                return;
            end
            chk("ct_latency", cyc - c0, n + 3);
            if (b == stall_byte) begin
                for (int k = 0; k < stall_len; k++) begin
                    chk("stall_ct_data", bus_if.ct_data, exp[b]);
                    chk("stall_ct_valid", bus_if.ct_valid, 1'b1);
                    chk("stall_pt_ready", bus_if.pt_ready, 1'b0);
                    @(negedge clk);
                end
            end else if (rnd) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            chk($sformatf("ct_byte%0d", b), bus_if.ct_data, exp[b]);
            bus_if.ct_ready = 1'b1;
            @(negedge clk);
            bus_if.ct_ready = 1'b0;
            if (b < 8) begin
                chk("pt_ready_after_ct", bus_if.pt_ready, 1'b1);
            end else begin
                chk("done_pulse", bus_if.done, 1'b1);
                chk("byte_count_final", bus_if.byte_count, 8'd9);
                @(negedge clk);
                chk("busy_cleared", bus_if.busy, 1'b0);
                chk("done_single", done_cnt - d0, 1);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus_if.busy, 1'b0);
        chk({tag, "_done"}, bus_if.done, 1'b0);
        chk({tag, "_pt_ready"}, bus_if.pt_ready, 1'b0);
        chk({tag, "_ct_valid"}, bus_if.ct_valid, 1'b0);
        chk({tag, "_ct_data"}, bus_if.ct_data, 8'h00);
        chk({tag, "_byte_count"}, bus_if.byte_count, 8'h00);
    endtask

    vec_t tbl [4];
    msg_t pt_m, ct_m;
    logic [23:0] rkey;
    int c0;

    initial begin
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.secret_key = '0;
        bus_if.pt_valid = 1'b0;
        bus_if.pt_data = '0;
        bus_if.ct_ready = 1'b0;

        tbl[0] = '{key: KAT_KEY, pt: KAT_PT, ct: KAT_CT};
        tbl[1] = '{key: KAT_KEY, pt: KAT_CT, ct: KAT_PT};
        for (int v = 2; v < 4; v++) begin
            tbl[v].key = 24'($urandom);
            tbl[v].pt  = {$urandom, $urandom, 8'($urandom)};
            to_msg(tbl[v].pt, pt_m);
            rc4_ref(tbl[v].key, pt_m, ct_m);
            for (int k = 0; k < 9; k++) tbl[v].ct[71-8*k -: 8] = ct_m[k];
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            to_msg(tbl[v].pt, pt_m);
            to_msg(tbl[v].ct, ct_m);
            run_msg(tbl[v].key, pt_m, ct_m, 0, (v == 0) ? 2 : -1, 10, 1'b0);
        end

        to_msg(KAT_PT, pt_m);
        to_msg(KAT_CT, ct_m);
        run_msg(KAT_KEY, pt_m, ct_m, 1, -1, 0, 1'b0);

        // Abort a run in the middle of KSA; outputs must clear asynchronously.
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.secret_key = KAT_KEY;
        @(negedge clk);
        bus_if.start = 1'b0;
        c0 = cyc - 1;
        while (cyc - c0 < 400) @(negedge clk);
        chk("busy_before_reset", bus_if.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        reset = 1'b0;
        run_msg(KAT_KEY, pt_m, ct_m, 0, -1, 0, 1'b0);

        run_msg(KAT_KEY, pt_m, ct_m, 3, -1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rkey = 24'($urandom);
            for (int k = 0; k < 9; k++) pt_m[k] = 8'($urandom);
            rc4_ref(rkey, pt_m, ct_m);
            run_msg(rkey, pt_m, ct_m, 0, int'($urandom_range(0, 8)), int'($urandom_range(1, 4)), 1'b1);
        end

        chk("pt_ready_ct_valid_exclusive", excl_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
